// File: rtl/opamp_out_monitor.sv
// Op-amp output monitor: counts high cycles and rising edges of the synchronised
// sense input over a programmable window. Optional majority filter: OPAMP_MON_GLITCH_FILTER_EN.
`timescale 1ns/1ps
module opamp_out_monitor #(
  parameter logic [31:0] BASE_ADR = 32'h3000_0100,
  parameter int          WIN_W    = 24
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_ni,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic [31:0] wbs_dat_o,
  output logic        wbs_ack_o,
  input  logic        sense_i,
  output logic        irq_o
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_MEASURE = 2'd1;
  localparam logic [1:0] ST_DONE    = 2'd2;

  localparam logic [WIN_W-1:0] CNT_MAX = '1;
  localparam logic [WIN_W-1:0] CNT_ONE = WIN_W'(1);

  // Increment with saturation; MSB of the result flags an attempted overflow.
  function automatic logic [WIN_W:0] sat_add(input logic [WIN_W-1:0] c, input logic inc);
    if (inc && (c == CNT_MAX))
      return {1'b1, c};
    return {1'b0, c + WIN_W'(inc)};
  endfunction

  function automatic logic [WIN_W-1:0] merge_bytes(input logic [WIN_W-1:0] old,
                                                   input logic [31:0] dat,
                                                   input logic [3:0] sel);
    logic [WIN_W-1:0] m;
    m = old;
    for (int i = 0; i < WIN_W; i++)
      if (sel[i/8]) m[i] = dat[i];
    return m;
  endfunction

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  logic             sync_p0, sync_p1;
  logic             s, s_d, rise;
  logic [1:0]       state;
  logic [WIN_W-1:0] win_cnt, hi_live, rc_live, high_cnt, rise_cnt, window;
  logic             cont, irq_en, done, ovf, busy;
  logic             hit, req, wr, rd;
  logic [2:0]       reg_idx;
  logic             start_wr, done_clr, ovf_clr, done_set, ovf_set;
  logic [WIN_W:0]   hi_sum, rc_sum;
  logic [31:0]      rdata;
  logic             unused_bits;

  assign unused_bits = ^{wbs_adr_i[1:0], wbs_dat_i};

  // Stage p0/p1: two-flop synchroniser on the asynchronous sense pin
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
    end else begin
      sync_p0 <= sense_i;
      sync_p1 <= sync_p0;
    end
  end

`ifdef OPAMP_MON_GLITCH_FILTER_EN
  logic filt_p2, filt_p3;
  // Stage p2/p3: majority over three consecutive samples rejects 1-cycle pulses
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      filt_p2 <= 1'b0;
      filt_p3 <= 1'b0;
      s       <= 1'b0;
    end else begin
      filt_p2 <= sync_p1;
      filt_p3 <= filt_p2;
      s       <= maj3(sync_p1, filt_p2, filt_p3);
    end
  end
`else
  assign s = sync_p1;
`endif

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) s_d <= 1'b0;
    else            s_d <= s;
  end

  assign rise = s & ~s_d;

  assign hit      = (wbs_adr_i[31:5] == BASE_ADR[31:5]);
  assign req      = wbs_cyc_i & wbs_stb_i & ~wbs_ack_o & hit;
  assign wr       = req & wbs_we_i;
  assign rd       = req & ~wbs_we_i;
  assign reg_idx  = wbs_adr_i[4:2];
  assign start_wr = wr & (reg_idx == 3'd0) & wbs_sel_i[0] & wbs_dat_i[0];
  assign done_clr = wr & (reg_idx == 3'd2) & wbs_sel_i[0] & wbs_dat_i[1];
  assign ovf_clr  = wr & (reg_idx == 3'd2) & wbs_sel_i[0] & wbs_dat_i[2];

  assign busy     = (state != ST_IDLE);
  assign hi_sum   = sat_add(hi_live, s);
  assign rc_sum   = sat_add(rc_live, rise);
  assign ovf_set  = (state == ST_MEASURE) & (hi_sum[WIN_W] | rc_sum[WIN_W]);
  assign done_set = (state == ST_DONE);
  assign irq_o    = done & irq_en;

  // Measurement FSM; a hardware DONE/OVF set takes priority over a W1C clear
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state    <= ST_IDLE;
      win_cnt  <= '0;
      hi_live  <= '0;
      rc_live  <= '0;
      high_cnt <= '0;
      rise_cnt <= '0;
      done     <= 1'b0;
      ovf      <= 1'b0;
    end else begin
      done <= done_set | (done & ~done_clr);
      ovf  <= ovf_set | (ovf & ~ovf_clr);
      case (state)
        ST_IDLE: begin
          if (start_wr) begin
            win_cnt <= window;
            hi_live <= '0;
            rc_live <= '0;
            state   <= (window == '0) ? ST_DONE : ST_MEASURE;
          end
        end
        ST_MEASURE: begin
          hi_live <= hi_sum[WIN_W-1:0];
          rc_live <= rc_sum[WIN_W-1:0];
          win_cnt <= win_cnt - CNT_ONE;
          if (win_cnt == CNT_ONE) state <= ST_DONE;
        end
        ST_DONE: begin
          high_cnt <= hi_live;
          rise_cnt <= rc_live;
          if (cont) begin
            win_cnt <= window;
            hi_live <= '0;
            rc_live <= '0;
            state   <= (window == '0) ? ST_DONE : ST_MEASURE;
          end else begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      cont   <= 1'b0;
      irq_en <= 1'b0;
      window <= '0;
    end else begin
      if (wr && (reg_idx == 3'd0) && wbs_sel_i[0]) begin
        cont   <= wbs_dat_i[1];
        irq_en <= wbs_dat_i[2];
      end
      if (wr && (reg_idx == 3'd1))
        window <= merge_bytes(window, wbs_dat_i, wbs_sel_i);
    end
  end

  always_comb begin
    rdata = 32'd0;
    case (reg_idx)
      3'd0:    rdata = {29'd0, irq_en, cont, 1'b0};
      3'd1:    rdata = 32'(window);
      3'd2:    rdata = {29'd0, ovf, done, busy};
      3'd3:    rdata = 32'(high_cnt);
      3'd4:    rdata = 32'(rise_cnt);
      default: rdata = 32'd0;
    endcase
  end

  // Registered single-cycle ack; read data only present alongside it
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      wbs_ack_o <= 1'b0;
      wbs_dat_o <= 32'd0;
    end else begin
      wbs_ack_o <= req;
      wbs_dat_o <= rd ? rdata : 32'd0;
    end
  end

endmodule

// File: doc/opamp_out_monitor.md
Name: opamp_out_monitor

Overview:
- Digital measurement stage directly downstream of the cascode op-amp.
- Samples the digital pad view of the op-amp output node (io_in[10]) and counts high cycles and rising edges over a programmable window of wb_clk_i cycles.
- Results are readable over Wishbone, with an optional done interrupt.
- Sits beside user_proj_example on the wrapper's Wishbone bus and drives one user_irq bit.

Parameters:
- BASE_ADR, 32'h3000_0100, Wishbone base address; block decodes BASE_ADR..BASE_ADR+0x1F.
- WIN_W, 24, width of WINDOW register and of all counters (1..32).

Ports:
- wb_clk_i  input  1  system clock.
- wb_rst_ni  input  1  reset; one clock; reset is asynchronous and active-low.
- wbs_cyc_i  input  1  Wishbone cycle.
- wbs_stb_i  input  1  Wishbone strobe.
- wbs_we_i  input  1  write enable.
- wbs_sel_i  input  4  byte enables.
- wbs_adr_i  input  32  byte address.
- wbs_dat_i  input  32  write data.
- wbs_dat_o  output  32  read data.
- wbs_ack_o  output  1  acknowledge.
- sense_i  input  1  asynchronous op-amp output sense (io_in[10]).
- irq_o  output  1  level interrupt = STATUS.DONE & CTRL.IRQ_EN.

Behaviour:
- Reset: all registers, counters, sync flops and FSM return to IDLE; wbs_ack_o=0, wbs_dat_o=0, irq_o=0.
- Input path:
  - 2-FF synchroniser on sense_i produces s.
  - rise = s & ~s_d (s_d is s delayed one cycle).
  - Latency from pin to s: 2 cycles.
- Register map (word offsets; writes honour wbs_sel_i per byte; undefined bits read 0):
  - 0x00 CTRL: b0 START (write-1 pulse, reads 0), b1 CONT, b2 IRQ_EN.
  - 0x04 WINDOW[WIN_W-1:0]: RW, reset 0.
  - 0x08 STATUS: b0 BUSY (RO), b1 DONE (write-1-to-clear), b2 OVF (write-1-to-clear).
  - 0x0C HIGH_CNT: RO, latched result.
  - 0x10 RISE_CNT: RO, latched result.
  - 0x14..0x1C: read 0, writes ignored.
- Wishbone:
  - Ack is registered: wbs_ack_o=1 in the cycle after cyc&stb&~ack for a decoded address; exactly 1 cycle wide.
  - Back-to-back accesses get an ack on every other cycle.
  - Addresses outside the decoded range: no ack, no effect.
  - wbs_dat_o is valid with ack; it is 0 when ack is not asserted.
- FSM states IDLE, MEASURE, DONE:
  - IDLE -> MEASURE on START write.
    - On entry: load win_cnt=WINDOW, clear live counters, BUSY=1.
    - If WINDOW=0, go to DONE next cycle with zero results.
  - MEASURE, each cycle:
    - hi += s, rc += rise, win_cnt -= 1.
    - Counters saturate at 2^WIN_W-1 and set OVF.
    - When win_cnt reaches 1 (last cycle counted) -> DONE.
  - DONE, one cycle:
    - Latch HIGH_CNT/RISE_CNT from the live counters including the final cycle's contribution.
    - Set DONE=1.
    - Then MEASURE (reload) if CONT=1, else IDLE with BUSY=0.
  - Window of N cycles counts exactly N samples of s.
- Boundary cases:
  - START while BUSY: ignored.
  - WINDOW write while BUSY: takes effect at the next load only.
  - Clearing CONT mid-window: the current window completes, then IDLE.
  - DONE W1C in the same cycle as a hardware DONE set: the set wins.
  - Same rule for OVF.
  - Reset asserted mid-window: immediate return to IDLE, results cleared.

Optional Feature:
- Macro OPAMP_MON_GLITCH_FILTER_EN.
- Defined:
  - A 3-sample majority filter follows the synchroniser: s = maj(s0,s1,s2).
  - Pin-to-s latency becomes 4 cycles.
  - Single-cycle pulses are rejected.
- Undefined: no filter, latency 2, s taken straight from the synchroniser.

Test Plan:
- Reset check: after reset, read all registers -> all 0; irq_o=0; read of 0x14 -> 0.
- Single window: WINDOW=100, sense_i toggles every 5 cycles (period 10), START -> DONE after 100 counted cycles; HIGH_CNT=50, RISE_CNT=10 (±1 on phase); BUSY then 0.
- Constant input: WINDOW=0 + START -> DONE set within 2 cycles, counts 0. Then sense_i=1 constant, WINDOW=16 -> HIGH_CNT=16, RISE_CNT=0.
- Continuous mode with interrupt: CONT=1, IRQ_EN=1, WINDOW=20 -> irq_o rises each window. Write DONE=1 -> irq_o drops, then reasserts next window. Clear CONT -> after the current window, BUSY=0.
- Saturation: WIN_W=4, WINDOW=15, sense_i=1 -> HIGH_CNT=15, OVF=0. With WINDOW=15 and 16 rises forced impossible, instead check START-while-busy is ignored: the counter is not reset mid-window.
- Mid-window reset and filter:
  - Assert wb_rst_ni low at cycle 10 of a 50-cycle window -> all registers 0, FSM IDLE.
  - With OPAMP_MON_GLITCH_FILTER_EN, 1-cycle pulses on sense_i -> RISE_CNT=0; without it -> each pulse counted.
